// File: rtl/recon_sum_4x4.sv
// Reconstruction stage: adds a 4x4 prediction block to its residual, clips to 8 bits,
// buffers the result in a 2-entry FIFO and returns the right column / bottom row to intra prediction.
module recon_sum_4x4 (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pred_valid,
  input  logic [127:0] pred,
  input  logic         res_valid,
  input  logic [143:0] res,
  input  logic [4:0]   blk_in,
  output logic         in_ready,
  output logic         recon_valid,
  output logic [127:0] recon,
  output logic [4:0]   recon_blk,
  input  logic         recon_ready,
  output logic         sum_valid,
  output logic [31:0]  sum_right_colum,
  output logic [31:0]  sum_bottom_row,
  output logic [4:0]   sum_blk
);

  logic signed [9:0] sum_pix [16];
  logic [127:0]      clip_pix;
  logic [132:0]      fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              acc;
  logic              pop;

  assign in_ready    = (count != 2'd2);
  assign recon_valid = (count != 2'd0);
  assign acc         = ena & pred_valid & res_valid & in_ready;
  assign pop         = ena & recon_valid & recon_ready;
  assign recon       = fifo_mem[rd_ptr][132:5];
  assign recon_blk   = fifo_mem[rd_ptr][4:0];

  // The 10-bit sum spans -256..510, so bit 9 flags underflow and bit 8 (with bit 9 clear) overflow.
  always_comb begin
    clip_pix = '0;
    for (int i = 0; i < 16; i++) begin
      sum_pix[i] = $signed({2'b00, pred[8*i +: 8]}) + $signed({res[9*i+8], res[9*i +: 9]});
      if (sum_pix[i][9])
        clip_pix[8*i +: 8] = 8'd0;
      else if (sum_pix[i][8])
        clip_pix[8*i +: 8] = 8'd255;
      else
        clip_pix[8*i +: 8] = sum_pix[i][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (acc) begin
        fifo_mem[wr_ptr] <= {clip_pix, blk_in};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (acc && !pop)
        count <= count + 2'd1;
      else if (pop && !acc)
        count <= count - 2'd1;
    end
  end

  // Neighbour return for intra prediction; data holds between accepts, valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid       <= 1'b0;
      sum_right_colum <= '0;
      sum_bottom_row  <= '0;
      sum_blk         <= '0;
    end else begin
      sum_valid <= acc;
      if (acc) begin
        sum_right_colum <= {clip_pix[127:120], clip_pix[95:88], clip_pix[63:56], clip_pix[31:24]};
        sum_bottom_row  <= clip_pix[127:96];
        sum_blk         <= blk_in;
      end
    end
  end

endmodule

// File: doc/recon_sum_4x4.md
# recon_sum_4x4

Reconstruction stage directly downstream of intra prediction: joins one 4x4 block of prediction samples with the matching 4x4 inverse-transform residual, adds and clips each sample to 8 bits, and buffers the reconstructed block in a 2-entry output FIFO for the frame-buffer writer. It also returns the block's right column and bottom row, with a one-cycle `sum_valid` pulse, to the intra prediction neighbour registers, which use them as `sum_right_colum` / `sum_bottom_row`.

## Interface
- No parameters. FIFO depth is fixed at 2. Sample width is fixed at 8 bits. Residual width is fixed at 9-bit signed.
- clk  in  1  sole clock; all logic samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; when low, all state is held.
- pred_valid  in  1  `pred` is valid.
- pred  in  128  prediction samples; byte i (bits 8i+7:8i) is pixel i, raster order, row = i/4, col = i%4.
- res_valid  in  1  `res` is valid.
- res  in  144  residuals; bits 9i+8:9i are the two's-complement residual for pixel i.
- blk_in  in  5  blk4x4 index tag accompanying the block.
- in_ready  out  1  block may be accepted; shared by the pred and res sides.
- recon_valid  out  1  FIFO head is valid.
- recon  out  128  reconstructed samples at the FIFO head, same byte layout as `pred`.
- recon_blk  out  5  tag at the FIFO head.
- recon_ready  in  1  downstream consumes the head.
- sum_valid  out  1  one-cycle pulse: `sum_*` hold the last accepted block.
- sum_right_colum  out  32  {p15,p11,p7,p3}, with p3 in bits 7:0.
- sum_bottom_row  out  32  {p15,p14,p13,p12}, with p12 in bits 7:0.
- sum_blk  out  5  tag of the block reported on `sum_*`.

## Operation
- **Join.** Acceptance is `acc = ena & pred_valid & res_valid & in_ready`. Neither side is consumed without the other. Upstream holds its data until `acc`.
- **in_ready.** `in_ready = (count != 2)`. It has no combinational path from `recon_ready`.
- **Arithmetic, per pixel i.**
  - `s = {2'b0,pred_i} + sign-extended res_i` (10-bit signed).
  - `p_i = 0` if s < 0; `p_i = 255` if s > 255; otherwise `p_i = s[7:0]`.
  - Add and clip are combinational ahead of the FIFO write.
- **FIFO.**
  - 2 entries, each {p0..p15, blk_in}; write pointer, read pointer and 2-bit count.
  - Pop condition: `ena & recon_valid & recon_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count 1; at count 2 push is blocked.
  - Pointers wrap 1 -> 0.
  - `recon_valid = (count != 0)`. `recon` and `recon_blk` are driven from the read-pointer entry.
- **Sum return.** On `acc`, register the sum outputs from the clipped pixels, load `sum_blk <= blk_in` and set `sum_valid <= 1`. Otherwise `sum_valid <= 0`.
  - `sum_right_colum` and `sum_bottom_row` hold their value until the next `acc`.
- **ena low.** No accept and no pop. `sum_valid` is forced to 0 on the next edge. FIFO contents, pointers and `sum_*` data are held.
- **Reset.** When `rst` is high at an edge:
  - count, pointers, `sum_valid`, `sum_right_colum`, `sum_bottom_row` and `sum_blk` go to 0.
  - `recon_valid` is therefore 0. FIFO storage is cleared to 0, so `recon` and `recon_blk` read 0.
  - Reset mid-operation discards buffered blocks; any in-flight `acc` in that cycle is ignored.

## Timing
- Block accepted at edge t:
  - It is visible on `recon` with `recon_valid=1` from edge t (when the FIFO was empty) until it is popped.
  - `sum_valid` is high for exactly the cycle after edge t.
- Throughput: one block per cycle while the downstream pops every cycle (count oscillates 0/1 or holds at 1).
- Back-pressure: with `recon_ready` low, two consecutive accepts fill the FIFO. `in_ready` drops after the second edge. The first pop re-raises `in_ready` on the following edge.
- The FIFO head is stable while `recon_valid & ~recon_ready`.
- All outputs are registered or driven from registers; there is no input-to-output combinational path.

## Test plan
- **Clip and layout.** Drive `pred` = all 0x80 and `res` pixel i = i*20-150. Required at the next edge:
  - p0=0 (-22 clips), p1=0, p7=118, p15=255 (278 clips);
  - `sum_right_colum` and `sum_bottom_row` match the byte order above;
  - `sum_valid` high for 1 cycle; `sum_blk = blk_in`.
- **Join.** Raise `pred_valid` 3 cycles before `res_valid`. Required: no accept and no `sum_valid` until both are high; accept exactly once.
- **Back-pressure.** Hold `recon_ready=0` and present blocks A, B, C back-to-back. Required:
  - A and B accepted, `in_ready=0`, C held;
  - raise `recon_ready` for one cycle: A is popped, `in_ready` rises, C is accepted on the next edge;
  - output order A, B, C.
- **Streaming.** Hold `recon_ready=1` and supply 16 consecutive blocks tagged 0..15. Required: 16 `sum_valid` pulses in 16 consecutive cycles, tags 0..15 in order, count never exceeds 1.
- **ena gating.** Drop `ena` for 2 cycles while count=1 and inputs are valid. Required: no accept, no pop, head unchanged; operation resumes when `ena` rises.
- **Reset.** Assert `rst` with count=2 and `sum_valid=1`. Required at the next edge: `recon_valid=0`, `sum_valid=0`, `in_ready=1`, all data outputs 0.
